// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - I-port, D-port and SRAM controller signals of sram_port_arbiter
interface sram_port_arbiter_if;
  logic        i_rd_en;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_rd_en;
  logic        d_wr_en;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        ctrl_rd_en;
  logic        ctrl_wr_en;
  logic [31:0] ctrl_addr;
  logic [31:0] ctrl_wdata;
  logic [31:0] ctrl_rdata;
  logic        ctrl_ready;

  modport slave (
    input  i_rd_en, i_addr, d_rd_en, d_wr_en, d_addr, d_wdata, ctrl_rdata, ctrl_ready,
    output i_rdata, i_ready, d_rdata, d_ready, ctrl_rd_en, ctrl_wr_en, ctrl_addr, ctrl_wdata
  );

  modport master (
    output i_rd_en, i_addr, d_rd_en, d_wr_en, d_addr, d_wdata, ctrl_rdata, ctrl_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, ctrl_rd_en, ctrl_wr_en, ctrl_addr, ctrl_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one SRAM controller between I-fetch and D-port
// ARB_ROUND_ROBIN_EN selects round-robin; default is fixed D priority with a MAX_WAIT starvation limit.
module sram_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input logic               CLK,
  input logic               RST,
  sram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

  state_t state;
  state_t state_nxt;
  logic   op_wr;
  logic   d_req;
  logic   grant_d;
  logic   grant_i;

  assign d_req = bus.d_rd_en | bus.d_wr_en;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_i;

  // Ties go to whichever port was not served last.
  assign grant_d = d_req & (~bus.i_rd_en | last_i);

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_i <= 1'b1;
    end else if (state == IDLE) begin
      if (grant_d) begin
        last_i <= 1'b0;
      end else if (grant_i) begin
        last_i <= 1'b1;
      end
    end
  end
`else
  logic [CNT_W-1:0] wait_cnt;
  logic             starved;

  assign starved = bus.i_rd_en & (wait_cnt == CNT_W'(MAX_WAIT));
  assign grant_d = d_req & ~starved;

  // Counts D grants made while fetch is waiting; anything else resets it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_d & bus.i_rd_en) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end
`endif

  assign grant_i = ~grant_d & bus.i_rd_en;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = GNT_D;
        end else if (grant_i) begin
          state_nxt = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (bus.ctrl_ready) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ctrl_rd_en = 1'b0;
    bus.ctrl_wr_en = 1'b0;
    bus.i_ready    = ~bus.i_rd_en;
    bus.d_ready    = ~d_req;
    case (state)
      GNT_I: begin
        bus.ctrl_rd_en = ~op_wr;
        bus.ctrl_wr_en = op_wr;
        if (bus.ctrl_ready) begin
          bus.i_ready = 1'b1;
        end
      end
      GNT_D: begin
        bus.ctrl_rd_en = ~op_wr;
        bus.ctrl_wr_en = op_wr;
        if (bus.ctrl_ready) begin
          bus.d_ready = 1'b1;
        end
      end
      DONE: begin
        bus.i_ready = 1'b1;
        bus.d_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Request fields are captured once at grant so port changes mid-access are ignored.
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_wr          <= 1'b0;
      bus.ctrl_addr  <= '0;
      bus.ctrl_wdata <= '0;
      bus.i_rdata    <= '0;
      bus.d_rdata    <= '0;
    end else begin
      if (state == IDLE) begin
        if (grant_d) begin
          op_wr          <= bus.d_wr_en;
          bus.ctrl_addr  <= bus.d_addr;
          bus.ctrl_wdata <= bus.d_wdata;
        end else if (grant_i) begin
          op_wr         <= 1'b0;
          bus.ctrl_addr <= bus.i_addr;
        end
      end
      if ((state == GNT_I) && bus.ctrl_ready) begin
        bus.i_rdata <= bus.ctrl_rdata;
      end
      if ((state == GNT_D) && bus.ctrl_ready && !op_wr) begin
        bus.d_rdata <= bus.ctrl_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
  localparam int MAX_WAIT = 4;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  sram_port_arbiter_if bus();

  sram_port_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_rd_en    = 1'b0;
    bus.i_addr     = '0;
    bus.d_rd_en    = 1'b0;
    bus.d_wr_en    = 1'b0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.ctrl_rdata = '0;
    bus.ctrl_ready = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle_inputs();
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    n_checks++; if (bus.ctrl_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_rd_en got %b exp 0", bus.ctrl_rd_en); end
    n_checks++; if (bus.ctrl_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl_wr_en got %b exp 0", bus.ctrl_wr_en); end
    n_checks++; if (bus.i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_i_ready got %b exp 1", bus.i_ready); end
    n_checks++; if (bus.d_ready !== 1'b1) begin n_fail++; $display("FAIL reset_d_ready got %b exp 1", bus.d_ready); end
    n_checks++; if (bus.i_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_i_rdata got %h exp 0", bus.i_rdata); end
    n_checks++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_d_rdata got %h exp 0", bus.d_rdata); end
    n_checks++; if (bus.ctrl_addr !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl_addr got %h exp 0", bus.ctrl_addr); end
    tick();
  endtask

  task automatic test_i_read();
    bus.i_rd_en = 1'b1;
    bus.i_addr  = 32'h40;
    @(negedge CLK);
    n_checks++; if (bus.i_ready !== 1'b0) begin n_fail++; $display("FAIL iread_idle_ready got %b exp 0", bus.i_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.ctrl_ready = (k == 2);
      bus.ctrl_rdata = (k == 2) ? 32'hDEADBEEF : $urandom;
      @(negedge CLK);
      n_checks++; if (bus.ctrl_rd_en !== 1'b1) begin n_fail++; $display("FAIL iread_rd_en cyc %0d got %b exp 1", k, bus.ctrl_rd_en); end
      n_checks++; if (bus.ctrl_addr !== 32'h40) begin n_fail++; $display("FAIL iread_addr cyc %0d got %h exp 40", k, bus.ctrl_addr); end
      n_checks++; if (bus.i_ready !== (k == 2)) begin n_fail++; $display("FAIL iread_ready cyc %0d got %b exp %b", k, bus.i_ready, k == 2); end
      tick();
    end
    bus.i_rd_en    = 1'b0;
    bus.ctrl_ready = 1'b0;
    @(negedge CLK);
    n_checks++; if (bus.ctrl_rd_en !== 1'b0) begin n_fail++; $display("FAIL iread_done_rd_en got %b exp 0", bus.ctrl_rd_en); end
    n_checks++; if (bus.i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL iread_rdata got %h exp deadbeef", bus.i_rdata); end
    tick();
    bus.ctrl_rdata = 32'h0BADF00D;
    @(negedge CLK);
    n_checks++; if (bus.i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL iread_rdata_hold got %h exp deadbeef", bus.i_rdata); end
    tick();
  endtask

  task automatic test_simultaneous();
    bus.i_rd_en = 1'b1;
    bus.i_addr  = 32'h200;
    bus.d_wr_en = 1'b1;
    bus.d_addr  = 32'h100;
    bus.d_wdata = 32'h12345678;
    @(negedge CLK);
    n_checks++; if ({bus.i_ready, bus.d_ready} !== 2'b00) begin n_fail++; $display("FAIL sim_idle_ready got %b exp 00", {bus.i_ready, bus.d_ready}); end
    tick();
    bus.ctrl_ready = 1'b1;
    bus.ctrl_rdata = 32'hFFFF0000;
    @(negedge CLK);
    n_checks++; if ({bus.ctrl_wr_en, bus.ctrl_rd_en} !== 2'b10) begin n_fail++; $display("FAIL sim_d_op got %b exp 10", {bus.ctrl_wr_en, bus.ctrl_rd_en}); end
    n_checks++; if (bus.ctrl_addr !== 32'h100) begin n_fail++; $display("FAIL sim_d_addr got %h exp 100", bus.ctrl_addr); end
    n_checks++; if (bus.ctrl_wdata !== 32'h12345678) begin n_fail++; $display("FAIL sim_d_wdata got %h exp 12345678", bus.ctrl_wdata); end
    n_checks++; if ({bus.i_ready, bus.d_ready} !== 2'b01) begin n_fail++; $display("FAIL sim_gnt_d_ready got %b exp 01", {bus.i_ready, bus.d_ready}); end
    tick();
    bus.d_wr_en    = 1'b0;
    bus.ctrl_ready = 1'b0;
    @(negedge CLK);
    n_checks++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL sim_write_keeps_d_rdata got %h exp 0", bus.d_rdata); end
    tick();
    @(negedge CLK);
    n_checks++; if (bus.i_ready !== 1'b0) begin n_fail++; $display("FAIL sim_idle_i_ready got %b exp 0", bus.i_ready); end
    tick();
    bus.ctrl_ready = 1'b1;
    bus.ctrl_rdata = 32'hCAFEF00D;
    @(negedge CLK);
    n_checks++; if (bus.ctrl_rd_en !== 1'b1 || bus.ctrl_addr !== 32'h200) begin n_fail++; $display("FAIL sim_i_grant got en %b addr %h exp 1 200", bus.ctrl_rd_en, bus.ctrl_addr); end
    n_checks++; if (bus.i_ready !== 1'b1) begin n_fail++; $display("FAIL sim_i_done_ready got %b exp 1", bus.i_ready); end
    tick();
    bus.i_rd_en    = 1'b0;
    bus.ctrl_ready = 1'b0;
    @(negedge CLK);
    n_checks++; if (bus.i_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sim_i_rdata got %h exp cafef00d", bus.i_rdata); end
    tick();
  endtask

  task automatic test_starvation();
    bit   grants[$];
    logic prev_en;
    bit   exp_d;
    do_reset();
    bus.i_rd_en = 1'b1;
    bus.i_addr  = 32'h1000;
    bus.d_rd_en = 1'b1;
    bus.d_addr  = 32'h2000;
    prev_en     = 1'b0;
    for (int c = 0; c < 100 && grants.size() < 10; c++) begin
      bus.ctrl_ready = bus.ctrl_rd_en | bus.ctrl_wr_en;
      @(negedge CLK);
      if (bus.ctrl_rd_en && !prev_en) grants.push_back(bus.ctrl_addr == 32'h2000);
      prev_en = bus.ctrl_rd_en;
      tick();
    end
    n_checks++; if (grants.size() != 10) begin n_fail++; $display("FAIL starve_grant_count got %0d exp 10", grants.size()); end
    foreach (grants[k]) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = (k % 2) == 0;
`else
      exp_d = (k % (MAX_WAIT + 1)) != MAX_WAIT;
`endif
      n_checks++; if (grants[k] !== exp_d) begin n_fail++; $display("FAIL starve_grant_%0d got d=%b exp d=%b", k, grants[k], exp_d); end
    end
    idle_inputs();
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.d_rd_en = 1'b1;
    bus.d_addr  = 32'h300;
    tick();
    bus.ctrl_ready = 1'b1;
    bus.ctrl_rdata = 32'hA5A50001;
    tick();
    bus.d_rd_en    = 1'b0;
    bus.ctrl_ready = 1'b0;
    @(negedge CLK);
    n_checks++; if (bus.d_rdata !== 32'hA5A50001) begin n_fail++; $display("FAIL rstmid_d_rdata got %h exp a5a50001", bus.d_rdata); end
    tick();
    bus.d_wr_en = 1'b1;
    bus.d_addr  = 32'h304;
    bus.d_wdata = 32'h77;
    tick();
    @(negedge CLK);
    n_checks++; if (bus.ctrl_wr_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_wr_en_before got %b exp 1", bus.ctrl_wr_en); end
    RST = 1'b1;
    tick();
    @(negedge CLK);
    n_checks++; if ({bus.ctrl_wr_en, bus.ctrl_rd_en} !== 2'b00) begin n_fail++; $display("FAIL rstmid_enables got %b exp 00", {bus.ctrl_wr_en, bus.ctrl_rd_en}); end
    n_checks++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_d_rdata_clr got %h exp 0", bus.d_rdata); end
    n_checks++; if (bus.d_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle_d_ready got %b exp 0", bus.d_ready); end
    RST = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    int          phase;
    int          wait_left;
    int          cnt;
    int          i_gap;
    int          d_gap;
    int          sel;
    bit          owner_d;
    bit          op_wr;
    bit          last_i;
    bit          i_pend;
    bit          d_pend;
    bit          cr;
    bit          pick_d;
    bit          exp_ir;
    bit          exp_dr;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_i_rdata;
    logic [31:0] m_d_rdata;
    do_reset();
    phase = 0; wait_left = 0; cnt = 0; i_gap = 0; d_gap = 0;
    owner_d = 0; op_wr = 0; last_i = 1; i_pend = 0; d_pend = 0;
    m_addr = '0; m_wdata = '0; m_i_rdata = '0; m_d_rdata = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!i_pend) begin
        if (i_gap > 0) i_gap--;
        else if ($urandom_range(0, 2) != 0) begin i_pend = 1; bus.i_addr = $urandom; end
      end
      bus.i_rd_en = i_pend;
      if (!d_pend) begin
        if (d_gap > 0) d_gap--;
        else if ($urandom_range(0, 2) != 0) begin
          d_pend      = 1;
          sel         = $urandom_range(0, 3);
          bus.d_rd_en = (sel != 1);
          bus.d_wr_en = (sel == 1) || (sel == 2);
          bus.d_addr  = $urandom;
          bus.d_wdata = $urandom;
        end
      end
      if (!d_pend) begin bus.d_rd_en = 1'b0; bus.d_wr_en = 1'b0; end
      cr             = (phase == 1) && (wait_left == 0);
      bus.ctrl_ready = cr;
      bus.ctrl_rdata = $urandom;
      @(negedge CLK);
      exp_ir = !i_pend || phase == 2 || (phase == 1 && !owner_d && cr);
      exp_dr = !d_pend || phase == 2 || (phase == 1 && owner_d && cr);
      n_checks++; if (bus.ctrl_rd_en !== (phase == 1 && !op_wr)) begin n_fail++; $display("FAIL rnd_rd_en c%0d got %b exp %b", c, bus.ctrl_rd_en, phase == 1 && !op_wr); end
      n_checks++; if (bus.ctrl_wr_en !== (phase == 1 && op_wr)) begin n_fail++; $display("FAIL rnd_wr_en c%0d got %b exp %b", c, bus.ctrl_wr_en, phase == 1 && op_wr); end
      n_checks++; if (bus.i_ready !== exp_ir) begin n_fail++; $display("FAIL rnd_i_ready c%0d got %b exp %b", c, bus.i_ready, exp_ir); end
      n_checks++; if (bus.d_ready !== exp_dr) begin n_fail++; $display("FAIL rnd_d_ready c%0d got %b exp %b", c, bus.d_ready, exp_dr); end
      n_checks++; if (bus.i_rdata !== m_i_rdata) begin n_fail++; $display("FAIL rnd_i_rdata c%0d got %h exp %h", c, bus.i_rdata, m_i_rdata); end
      n_checks++; if (bus.d_rdata !== m_d_rdata) begin n_fail++; $display("FAIL rnd_d_rdata c%0d got %h exp %h", c, bus.d_rdata, m_d_rdata); end
      if (phase == 1) begin
        n_checks++; if (bus.ctrl_addr !== m_addr) begin n_fail++; $display("FAIL rnd_addr c%0d got %h exp %h", c, bus.ctrl_addr, m_addr); end
        if (op_wr) begin
          n_checks++; if (bus.ctrl_wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata c%0d got %h exp %h", c, bus.ctrl_wdata, m_wdata); end
        end
      end
      if (phase == 1) begin
        if (cr) begin
          if (!op_wr) begin
            if (owner_d) m_d_rdata = bus.ctrl_rdata;
            else m_i_rdata = bus.ctrl_rdata;
          end
          if (owner_d) begin d_pend = 0; d_gap = $urandom_range(0, 2); end
          else begin i_pend = 0; i_gap = $urandom_range(0, 2); end
          phase = 2;
        end else begin
          wait_left--;
        end
      end else if (phase == 2) begin
        phase = 0;
      end else begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = d_pend && (!i_pend || last_i);
`else
        pick_d = d_pend && !(i_pend && cnt == MAX_WAIT);
`endif
        if (pick_d) begin
          phase = 1; owner_d = 1; op_wr = bus.d_wr_en; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
          cnt = i_pend ? cnt + 1 : 0; last_i = 0;
        end else if (i_pend) begin
          phase = 1; owner_d = 0; op_wr = 0; m_addr = bus.i_addr; cnt = 0; last_i = 1;
        end else begin
          cnt = 0;
        end
        if (phase == 1) wait_left = $urandom_range(0, 3);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    test_reset();
    test_i_read();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one SRAM controller between the instruction-fetch port (read-only) and the MEM-stage data port (read/write).
- Sits between the IF/MEM stages and the SRAM controller.
- Latches the winning request, drives the controller's enable/address/data, and returns per-port ready (freeze_N semantics) and read data.
- Fixed data priority with a starvation limit for instruction fetch.

Parameters:
- MAX_WAIT, 4, number of consecutive data grants allowed while the I-port is waiting; the next grant then goes to the I-port.
- CNT_W, 3, width of the starvation counter; must hold MAX_WAIT.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- i_rd_en  in  1  instruction read request, held until i_ready
- i_addr  in  32  instruction byte address
- i_rdata  out  32  instruction read data
- i_ready  out  1  1 = I-port not stalled
- d_rd_en  in  1  data read request, held until d_ready
- d_wr_en  in  1  data write request, held until d_ready
- d_addr  in  32  data byte address
- d_wdata  in  32  data write value
- d_rdata  out  32  data read result
- d_ready  out  1  1 = D-port not stalled
- ctrl_rd_en  out  1  read enable to SRAM controller
- ctrl_wr_en  out  1  write enable to SRAM controller
- ctrl_addr  out  32  address to controller
- ctrl_wdata  out  32  write data to controller
- ctrl_rdata  in  32  controller read data, valid when ctrl_ready=1
- ctrl_ready  in  1  controller completion; high for the finishing cycle while its enable is held

Behaviour:
- Clock and reset: one clock CLK; synchronous active-high reset RST.
- States: IDLE, GNT_I, GNT_D, DONE.
- Reset values: state=IDLE; ctrl_rd_en=ctrl_wr_en=0; ctrl_addr=ctrl_wdata=0; i_rdata=d_rdata=0; starvation counter=0.
- i_ready and d_ready are combinational from state and inputs.
- IDLE arbitration:
  - If d_req (d_rd_en|d_wr_en) and I is not starved: go to GNT_D.
  - Else if i_rd_en: go to GNT_I.
  - Else stay in IDLE.
  - On the transition, register ctrl_addr/ctrl_wdata and the op from the winning port.
  - d_rd_en and d_wr_en both high: treated as a write.
- Starvation:
  - The counter increments on each D grant made while i_rd_en=1.
  - It clears on any I grant, or when i_rd_en=0 in IDLE.
  - When the counter equals MAX_WAIT, I wins even if d_req is high.
- GNT_x:
  - ctrl_rd_en / ctrl_wr_en are held high from registered op bits.
  - Port input changes are ignored; latched values are used.
  - When ctrl_ready=1: x_ready=1 this cycle, x_rdata is loaded from ctrl_rdata (reads only), then go to DONE.
- DONE:
  - Enables are low; one bubble cycle so the finished port's next request is sampled fresh.
  - Then go to IDLE.
- Ready rules:
  - x_ready=0 while x requests and (state is IDLE, the other port's grant, or x's grant without ctrl_ready).
  - x_ready=1 when x has no request, in x's completion cycle, and in DONE.
- Read data: x_rdata holds its value until the next read completion on that port. Writes do not change d_rdata.
- Minimum latency: request at cycle N in IDLE → grant at N+1 → completion at or after N+1.
- Reset mid-operation: state returns to IDLE and enables drop the next edge. The controller shares RST and aborts too.
- Simultaneous first requests after reset: D wins.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - The starvation counter and MAX_WAIT are unused.
  - A 1-bit last-granted pointer gives priority to the port not granted last.
  - Pointer reset value = I-port last, so D wins first.
- Undefined: fixed D priority with the MAX_WAIT starvation limit, as specified above.

Test Plan:
- Reset, no requests → all enables 0, i_ready=d_ready=1, rdata=0.
- i_rd_en=1, i_addr=0x40, controller completes 3 cycles after grant with ctrl_rdata=0xDEADBEEF → ctrl_rd_en high 3 cycles with ctrl_addr=0x40; i_ready pulses 1; i_rdata=0xDEADBEEF and holds.
- Same-cycle i_rd_en and d_wr_en (d_addr=0x100, d_wdata=0x12345678) → D granted first (ctrl_wr_en, addr 0x100); i_ready=0 until I is granted after DONE+IDLE.
- d_req held continuously with i_rd_en=1 and MAX_WAIT=4 → 4 D grants, then an I grant; counter clears.
- RST asserted in GNT_D mid-access → next cycle state IDLE, ctrl_wr_en=0, d_rdata=0.
- ARB_ROUND_ROBIN_EN defined, both ports requesting continuously → grants alternate D, I, D, I.
